// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit asynchronous SRAM access controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } sram_state_t;

    typedef enum logic {
        READ,
        WRITE
    } sram_op_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    // A simultaneous read and write request resolves to a write.
    function automatic sram_op_t req_op(input logic wr_en);
        return wr_en ? WRITE : READ;
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that paces each half-word SRAM phase; last is high on the final cycle.
module sram_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit data-memory accesses into two timed 16-bit asynchronous SRAM accesses.
// Optional address range checking is enabled with the SRAM_CTRL_RANGE_CHECK_EN macro.
//
// state | meaning
// IDLE  | no access in flight; ready when no request is present
// LO    | low half-word access, held for WAIT_CYCLES cycles
// HI    | high half-word access, held for WAIT_CYCLES cycles
// DONE  | ready for one cycle while the pipeline advances
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W = SRAM_AW - 1;

    sram_state_t      state;
    sram_state_t      state_nx;
    sram_op_t         op;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      wdata_hi_q;

    logic             req;
    logic             last;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;
    logic             reject;
    logic             range_bad;
    logic [31:0]      addr_off;
    logic [IDX_W-1:0] idx_in;

    assign req      = rd_en | wr_en;
    assign addr_off = addr - BASE_ADDR;
    assign idx_in   = addr_off[SRAM_AW:2];

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign range_bad = (addr < BASE_ADDR) | (addr[1:0] != 2'b00) |
                       (addr_off[31:SRAM_AW+1] != '0);
`else
    // Without range checking the word index simply wraps into the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};
    assign range_bad        = 1'b0;
`endif

    sram_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (range_bad) begin
                        reject   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        accept   = 1'b1;
                        cnt_load = 1'b1;
                        state_nx = LO;
                    end
                end
            end
            LO: begin
                cnt_dec = 1'b1;
                if (last) begin
                    cnt_load = 1'b1;
                    state_nx = HI;
                end
            end
            HI: begin
                cnt_dec = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // Pin values are registered one edge ahead so they are stable for the whole phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            op          <= READ;
            idx_q       <= '0;
            wdata_hi_q  <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            if (accept) begin
                op          <= req_op(wr_en);
                idx_q       <= idx_in;
                wdata_hi_q  <= wdata[31:16];
                sram_addr   <= {idx_in, 1'b0};
                sram_dq_out <= wdata[15:0];
                sram_we_n   <= ~wr_en;
                sram_dq_oe  <= wr_en;
            end
            if ((state == LO) && last) begin
                if (op == READ) begin
                    rdata[15:0] <= sram_dq_in;
                end
                sram_addr   <= {idx_q, 1'b1};
                sram_dq_out <= wdata_hi_q;
            end
            if ((state == HI) && last) begin
                if (op == READ) begin
                    rdata[31:16] <= sram_dq_in;
                end
                sram_we_n  <= 1'b1;
                sram_dq_oe <= 1'b0;
            end
            if (reject && !wr_en) begin
                rdata <= '0;
            end
        end
    end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (reject) begin
            err <= 1'b1;
        end else if (accept) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: word-level memory model, SRAM pin model, randomized traffic.
module tb_sram_ctrl;

    localparam int          W       = 2;
    localparam int          AW      = 18;
    localparam logic [31:0] BASE    = 32'd1024;
    localparam int          NWORDS  = 32;

    logic          clk;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    sram_ctrl #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .err         (err),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          fails     = 0;
    int          txn_id    = 0;
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] last_rdata;
    logic        mem_init;

    function automatic logic [15:0] init_val(input int i);
        case (i)
            2:       return 16'h1234;
            3:       return 16'hABCD;
            default: return 16'(i * 16'h00F1) ^ 16'hC3A5;
        endcase
    endfunction

    // Asynchronous SRAM pin model: a write lands at the end of each strobed cycle
    // unless the controller is reset on that edge.
    logic [15:0] sram_mem [2*NWORDS];
    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2*NWORDS; i++) sram_mem[i] <= init_val(i);
        end else if (!rst && !sram_we_n) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model works on whole 32-bit words indexed by word number.
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic in_range);
        exp_t e;
        int   idx;
        idx = int'((a - BASE) >> 2);
        txn_id++;
        if (!in_range) begin
            if (!w) last_rdata = 32'h0;
            e.err = 1'b1;
        end else begin
            if (w) ref_mem[idx] = d;
            else   last_rdata = ref_mem[idx];
            e.err = 1'b0;
        end
        e.rdata = last_rdata;
        e.id    = txn_id;
        exp_q.push_back(e);
    endtask

    task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input bit scramble, input bit in_range);
        int          n;
        int          half;
        int          idx;
        int          exp_len;
        bit          done;
        logic [31:0] addr_before;
        idx     = int'((a - BASE) >> 2);
        exp_len = in_range ? 2*W + 2 : 2;
        @(posedge clk);
        #1;
        rd_en = r;
        wr_en = w;
        addr  = a;
        wdata = d;
        addr_before = 32'(sram_addr);
        n    = 0;
        done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (ready) done = 1;
            if (in_range && n >= 2 && n <= 2*W + 1) begin
                half = (n - 2) / W;
                chk("phase_addr", 32'(sram_addr), 32'(2*idx + half));
                chk("phase_we_n", 32'(sram_we_n), 32'(!w));
                chk("phase_oe", 32'(sram_dq_oe), 32'(w));
                if (w) chk("phase_dq", 32'(sram_dq_out), half != 0 ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                chk("idle_we_n", 32'(sram_we_n), 32'h1);
                chk("idle_oe", 32'(sram_dq_oe), 32'h0);
                if (!in_range) chk("err_no_addr_activity", 32'(sram_addr), addr_before);
            end
            if (!done && scramble && n >= 2) begin
                addr  = $urandom;
                wdata = $urandom;
                case ($urandom_range(0, 2))
                    0:       begin rd_en = 1'b1; wr_en = 1'b0; end
                    1:       begin rd_en = 1'b0; wr_en = 1'b1; end
                    default: begin rd_en = 1'b1; wr_en = 1'b1; end
                endcase
            end
        end
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL ready_timeout: got no ready after %0d cycles expected %0d", n, exp_len);
        end else begin
            chk("ready_latency", 32'(n), 32'(exp_len));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            wr_en = 1'b0;
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'h1);
        end
    endtask

    // Monitor: every DONE (ready with a request still present) retires one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ready && (rd_en || wr_en)) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_done: got ready with request, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("txn%0d_rdata", e.id), rdata, e.rdata);
                    chk($sformatf("txn%0d_err", e.id), 32'(err), 32'(e.err));
                end
            end
            if (!sram_we_n) begin
                chk("strobe_oe", 32'(sram_dq_oe), 32'h1);
                chk("strobe_addr_range", 32'(sram_addr < AW'(2*NWORDS)), 32'h1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion by 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] old;
        logic [31:0] a;
        logic        r;
        logic        w;
        int          op;

        for (int i = 0; i < NWORDS; i++)
            ref_mem[i] = {init_val(2*i + 1), init_val(2*i)};
        last_rdata = 32'h0;
        mem_init   = 1'b1;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        addr       = 32'h0;
        wdata      = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_we_n", 32'(sram_we_n), 32'h1);
        chk("rst_oe", 32'(sram_dq_oe), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);

        model_push(1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
        run_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(1);

        model_push(1'b0, 32'd1028, 32'h0, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1);
        chk("read_1028_value", last_rdata, 32'hABCD1234);
        idle(1);

        model_push(1'b1, 32'd1028, 32'h0BADF00D, 1'b1);
        run_txn(1'b1, 1'b1, 32'd1028, 32'h0BADF00D, 1'b0, 1'b1);
        model_push(1'b0, 32'd1028, 32'h0, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1);
        idle(1);

        // Reset during the high-half phase of a write abandons the high half.
        old = ref_mem[3];
        d   = $urandom;
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        rd_en = 1'b0;
        addr  = BASE + 32'd12;
        wdata = d;
        repeat (W + 2) @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("midrst_we_n", 32'(sram_we_n), 32'h1);
        chk("midrst_oe", 32'(sram_dq_oe), 32'h0);
        chk("midrst_ready_idle", 32'(ready), 32'h1);
        chk("midrst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_mem[3] = {old[31:16], d[15:0]};
        last_rdata = 32'h0;
        model_push(1'b0, BASE + 32'd12, 32'h0, 1'b1);
        run_txn(1'b1, 1'b0, BASE + 32'd12, 32'h0, 1'b0, 1'b1);
        idle(1);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        model_push(1'b0, 32'd1000, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 32'd1000, 32'h0, 1'b0, 1'b0);
        model_push(1'b1, 32'd1026, 32'h12345678, 1'b0);
        run_txn(1'b0, 1'b1, 32'd1026, 32'h12345678, 1'b0, 1'b0);
        idle(1);
`endif

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            r  = (op != 1);
            w  = (op != 0);
            a  = BASE + 32'($urandom_range(0, NWORDS - 1)) * 32'd4;
            d  = $urandom;
            model_push(w, a, d, 1'b1);
            run_txn(r, w, a, d, 1'b1, 1'b1);
            op = $urandom_range(0, 2);
            if (op != 0) idle(op);
        end
        idle(2);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
